// File: rtl/osc_pkg.sv
// Shared constants for the oscilloscope decimator slice.
package osc_pkg;
  localparam int DW_DEF   = 16;
  localparam int DECW_DEF = 17;
  localparam int SHIFT_W  = 5;
  // Saturation limits for the default sample width
  localparam logic [DW_DEF-1:0] SAT_MAX_DEF = 16'h7FFF;
  localparam logic [DW_DEF-1:0] SAT_MIN_DEF = 16'h8000;
endpackage

// File: rtl/osc_sat_shift.sv
// Arithmetic right shift of a wide signed value followed by clamp to OW-bit signed range.
module osc_sat_shift
  import osc_pkg::*;
#(
  parameter int IW = 33,
  parameter int OW = 16
) (
  input  logic signed [IW-1:0]      din,
  input  logic        [SHIFT_W-1:0] shamt,
  output logic        [OW-1:0]      dout
);
  logic signed [IW-1:0] shr;
  logic        [IW-OW:0] hi;
  logic                  ovf;

  assign shr = din >>> shamt;
  // Result fits only if every bit from the OW-1 sign position upward agrees
  assign hi  = shr[IW-1:OW-1];
  assign ovf = ~((&hi) | ~(|hi));
  assign dout = ovf ? {shr[IW-1], {(OW-1){~shr[IW-1]}}} : shr[OW-1:0];
endmodule

// File: rtl/osc_decimator.sv
// AXI-Stream decimator: one output per block of N input beats, either the last sample
// or the saturated, shifted block sum. Any config change restarts the block.
module osc_decimator
  import osc_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int DECW = DECW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DW-1:0]      s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [DW-1:0]      m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  input  logic [DECW-1:0]    cfg_dec,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               cfg_avg,
  output logic [DECW-1:0]    sts_blk_cnt
);
  localparam int AW = DW + DECW;

  logic [DECW-1:0]      dec_q;
  logic [SHIFT_W-1:0]   shift_q;
  logic                 avg_q;
  logic [DECW-1:0]      cnt;
  logic [DECW-1:0]      cnt_last;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_nxt;
  logic [DW-1:0]        avg_dout;
  logic                 accept;
  logic                 cfg_chg;
  logic                 blk_end;
  logic                 out_taken;

  assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign out_taken     = m_axis_tvalid & m_axis_tready;
  assign cfg_chg       = (cfg_dec != dec_q) | (cfg_shift != shift_q) | (cfg_avg != avg_q);
  // A factor of 0 behaves as 1, so the last index is 0 either way
  assign cnt_last      = (dec_q == '0) ? '0 : dec_q - DECW'(1);
  assign blk_end       = accept & ~cfg_chg & (cnt == cnt_last);
  assign acc_nxt       = acc + {{DECW{s_axis_tdata[DW-1]}}, s_axis_tdata};
  assign sts_blk_cnt   = cnt;

  osc_sat_shift #(.IW(AW), .OW(DW)) u_sat (
    .din   (acc_nxt),
    .shamt (shift_q),
    .dout  (avg_dout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_q         <= cfg_dec;
      shift_q       <= cfg_shift;
      avg_q         <= cfg_avg;
      cnt           <= '0;
      acc           <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (cfg_chg) begin
      // Restart the block; the input beat is dropped but a pending output survives
      dec_q   <= cfg_dec;
      shift_q <= cfg_shift;
      avg_q   <= cfg_avg;
      cnt     <= '0;
      acc     <= '0;
      if (out_taken) m_axis_tvalid <= 1'b0;
    end else begin
      if (accept) begin
        if (blk_end) begin
          cnt <= '0;
          acc <= '0;
        end else begin
          cnt <= cnt + DECW'(1);
          acc <= acc_nxt;
        end
      end
      if (blk_end) begin
        m_axis_tdata  <= avg_q ? avg_dout : s_axis_tdata;
        m_axis_tvalid <= 1'b1;
      end else if (out_taken) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end
endmodule
